// File: rtl/riscv_pipe_pkg.sv
// Shared widths and per-stage control encodings for the core's inter-stage registers.
// The all-zero control word is the architectural no-op used for bubbles.
package riscv_pipe_pkg;

    localparam int XLEN       = 32;
    localparam int WBSEL_W    = 2;
    localparam int CTRL_W_DEF = 8;

    typedef struct packed {
        logic               trap_req;
        logic               pred_taken;
        logic [5:0]         rsvd;
    } if_id_ctrl_t;

    typedef struct packed {
        logic               reg_wen;
        logic [WBSEL_W-1:0] wb_sel;
        logic               trap_req;
        logic               is_jalr;
        logic               mem_ren;
        logic               mem_wen;
        logic               br_en;
    } id_ex_ctrl_t;

    typedef struct packed {
        logic               reg_wen;
        logic [WBSEL_W-1:0] wb_sel;
        logic               trap_req;
        logic               mem_ren;
        logic               mem_wen;
        logic [1:0]         mem_size;
    } ex_mem_ctrl_t;

    typedef struct packed {
        logic               reg_wen;
        logic [WBSEL_W-1:0] wb_sel;
        logic               trap_req;
        logic [3:0]         rsvd;
    } mem_wb_ctrl_t;

    localparam logic [CTRL_W_DEF-1:0] CTRL_NOP = '0;

endpackage

// File: rtl/pipe_skid_buf.sv
// Second holding entry for the pipeline register; catches the one input accepted
// while the main entry is stalled, so the upstream ready can be a flop.
module pipe_skid_buf
    import riscv_pipe_pkg::*;
#(
    parameter int DATA_W = 3 * XLEN,
    parameter int CTRL_W = CTRL_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              load,
    input  logic              drain,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              valid,
    output logic [DATA_W-1:0] data,
    output logic [CTRL_W-1:0] ctrl
);

    always_ff @(posedge clk) begin
        if (reset) begin
            valid <= 1'b0;
            data  <= '0;
            ctrl  <= CTRL_W'(CTRL_NOP);
        end else if (flush) begin
            valid <= 1'b0;
            ctrl  <= CTRL_W'(CTRL_NOP);
        end else if (load) begin
            valid <= 1'b1;
            data  <= in_data;
            ctrl  <= in_ctrl;
        end else if (drain) begin
            valid <= 1'b0;
            ctrl  <= CTRL_W'(CTRL_NOP);
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register with valid/ready handshake and flush-to-bubble.
// Define PIPE_SKID_EN to add a skid entry and make in_ready a registered signal.
module pipe_stage_reg
    import riscv_pipe_pkg::*;
#(
    parameter int DATA_W = 3 * XLEN,
    parameter int CTRL_W = $bits(id_ex_ctrl_t)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl
);

    logic              main_valid, main_valid_nxt;
    logic [DATA_W-1:0] main_data, main_data_nxt;
    logic [CTRL_W-1:0] main_ctrl, main_ctrl_nxt;
    logic              emit;
    logic              accept;

    assign emit   = main_valid && out_ready;
    assign accept = in_valid && in_ready;

`ifdef PIPE_SKID_EN
    logic              skid_valid;
    logic [DATA_W-1:0] skid_data;
    logic [CTRL_W-1:0] skid_ctrl;
    logic              skid_load;
    logic              skid_drain;

    // skid_valid is a flop, so upstream never sees a path from out_ready
    assign in_ready   = !skid_valid;
    assign skid_load  = accept && main_valid && !emit;
    assign skid_drain = skid_valid && emit;

    pipe_skid_buf #(
        .DATA_W (DATA_W),
        .CTRL_W (CTRL_W)
    ) u_skid (
        .clk     (clk),
        .reset   (reset),
        .flush   (flush),
        .load    (skid_load),
        .drain   (skid_drain),
        .in_data (in_data),
        .in_ctrl (in_ctrl),
        .valid   (skid_valid),
        .data    (skid_data),
        .ctrl    (skid_ctrl)
    );

    always_comb begin
        main_valid_nxt = main_valid;
        main_data_nxt  = main_data;
        main_ctrl_nxt  = main_ctrl;
        if (skid_drain) begin
            main_valid_nxt = 1'b1;
            main_data_nxt  = skid_data;
            main_ctrl_nxt  = skid_ctrl;
        end else if (!main_valid || emit) begin
            if (accept) begin
                main_valid_nxt = 1'b1;
                main_data_nxt  = in_data;
                main_ctrl_nxt  = in_ctrl;
            end else begin
                main_valid_nxt = 1'b0;
                main_ctrl_nxt  = CTRL_W'(CTRL_NOP);
            end
        end
    end
`else
    assign in_ready = !main_valid || out_ready;

    always_comb begin
        main_valid_nxt = main_valid;
        main_data_nxt  = main_data;
        main_ctrl_nxt  = main_ctrl;
        if (in_ready) begin
            if (in_valid) begin
                main_valid_nxt = 1'b1;
                main_data_nxt  = in_data;
                main_ctrl_nxt  = in_ctrl;
            end else begin
                main_valid_nxt = 1'b0;
                main_ctrl_nxt  = CTRL_W'(CTRL_NOP);
            end
        end
    end
`endif

    // out_data is left alone on flush; only valid and ctrl define a bubble
    always_ff @(posedge clk) begin
        if (reset) begin
            main_valid <= 1'b0;
            main_data  <= '0;
            main_ctrl  <= CTRL_W'(CTRL_NOP);
        end else if (flush) begin
            main_valid <= 1'b0;
            main_ctrl  <= CTRL_W'(CTRL_NOP);
        end else begin
            main_valid <= main_valid_nxt;
            main_data  <= main_data_nxt;
            main_ctrl  <= main_ctrl_nxt;
        end
    end

    assign out_valid = main_valid;
    assign out_data  = main_data;
    assign out_ctrl  = main_ctrl;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed vector table plus flush and random-stream scoreboard checks for pipe_stage_reg.
// Expectations follow PIPE_SKID_EN when the bench is built with it.
module tb_pipe_stage_reg;

    localparam int DW = 96;
    localparam int CW = 8;
`ifdef PIPE_SKID_EN
    localparam bit SKID = 1'b1;
`else
    localparam bit SKID = 1'b0;
`endif

    logic          clk;
    logic          reset;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic [CW-1:0] in_ctrl;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [CW-1:0] out_ctrl;

    int errors = 0;
    int checks = 0;

    pipe_stage_reg #(
        .DATA_W (DW),
        .CTRL_W (CW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_ctrl   (in_ctrl),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ctrl  (out_ctrl)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        bit          rst;
        bit          fl;
        bit          iv;
        logic [31:0] id;
        logic [7:0]  ic;
        bit          ordy;
        bit          chk;
        bit          ev;
        logic [31:0] ed;
        logic [7:0]  ec;
        bit          er;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(bit rst, bit fl, bit iv, logic [31:0] id, logic [7:0] ic, bit ordy,
                                bit chk, bit ev, logic [31:0] ed, logic [7:0] ec, bit er);
        vec_t v;
        v.rst = rst; v.fl = fl; v.iv = iv; v.id = id; v.ic = ic; v.ordy = ordy;
        v.chk = chk; v.ev = ev; v.ed = ed; v.ec = ec; v.er = er;
        return v;
    endfunction

    task automatic check(string name, logic [DW-1:0] got, logic [DW-1:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    task automatic drive(bit rst, bit fl, bit iv, logic [DW-1:0] d, logic [CW-1:0] c, bit ordy);
        reset     = rst;
        flush     = fl;
        in_valid  = iv;
        in_data   = d;
        in_ctrl   = c;
        out_ready = ordy;
    endtask

    // Cycle boundary: outputs are sampled at the negedge, inputs change 1 after the posedge
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    logic [DW-1:0] exp_q[$];
    logic [CW-1:0] expc_q[$];

    initial begin
        logic [31:0] ab;
        logic [31:0] bb;
        logic [DW-1:0] d;
        logic [CW-1:0] c;
        int sent;
        int rcvd;
        int cyc;
        bit acc;
        bit emt;

        ab = SKID ? 32'hB : 32'hA;
        bb = SKID ? 32'hB : 32'hA;
        // reset held 2 cycles with in_valid
        vecs.push_back(mk(1,0,1,32'h99,8'h7F,0, 0,0,0,0,0));
        vecs.push_back(mk(1,0,1,32'h99,8'h7F,0, 1,0,0,0,1));
        vecs.push_back(mk(0,0,0,0,0,1,           1,0,0,0,1));
        // back-to-back stream
        vecs.push_back(mk(0,0,1,32'h10,8'h05,1,  1,0,0,0,1));
        vecs.push_back(mk(0,0,1,32'h14,8'h05,1,  1,1,32'h10,8'h05,1));
        vecs.push_back(mk(0,0,1,32'h18,8'h05,1,  1,1,32'h14,8'h05,1));
        vecs.push_back(mk(0,0,0,0,0,1,           1,1,32'h18,8'h05,1));
        vecs.push_back(mk(0,0,0,0,0,1,           1,0,32'h18,8'h00,1));
        // stall: push A then B with out_ready low
        vecs.push_back(mk(0,0,1,32'hA,8'h11,0,   1,0,32'h18,8'h00,1));
        vecs.push_back(mk(0,0,1,32'hB,8'h22,0,   1,1,32'hA,8'h11,SKID));
        vecs.push_back(mk(0,0,0,0,0,0,           1,1,32'hA,8'h11,0));
        vecs.push_back(mk(0,0,0,0,0,1,           1,1,32'hA,8'h11,!SKID));
        vecs.push_back(mk(0,0,0,0,0,1,           1,SKID,ab,SKID ? 8'h22 : 8'h00,1));
        vecs.push_back(mk(0,0,0,0,0,1,           1,0,bb,8'h00,1));
        // flush with a live input that must be dropped
        vecs.push_back(mk(0,0,1,32'hD,8'h81,0,   1,0,bb,8'h00,1));
        vecs.push_back(mk(0,0,0,0,0,0,           1,1,32'hD,8'h81,SKID));
        vecs.push_back(mk(0,1,1,32'hC,8'h33,1,   1,1,32'hD,8'h81,1));
        vecs.push_back(mk(0,0,0,0,0,1,           1,0,32'hD,8'h00,1));
        vecs.push_back(mk(0,0,0,0,0,1,           1,0,32'hD,8'h00,1));
        // reset with both entries occupied
        vecs.push_back(mk(0,0,1,32'h1A,8'h44,0,  1,0,32'hD,8'h00,1));
        vecs.push_back(mk(0,0,1,32'h1B,8'h55,0,  1,1,32'h1A,8'h44,SKID));
        vecs.push_back(mk(1,0,0,0,0,0,           1,1,32'h1A,8'h44,0));
        vecs.push_back(mk(0,0,0,0,0,1,           1,0,0,8'h00,1));
        vecs.push_back(mk(0,0,0,0,0,1,           1,0,0,8'h00,1));

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].rst, vecs[i].fl, vecs[i].iv, {3{vecs[i].id}}, vecs[i].ic, vecs[i].ordy);
            @(negedge clk);
            if (vecs[i].chk) begin
                check($sformatf("row%0d out_valid", i), DW'(out_valid), DW'(vecs[i].ev));
                check($sformatf("row%0d out_data", i), out_data, {3{vecs[i].ed}});
                check($sformatf("row%0d out_ctrl", i), DW'(out_ctrl), DW'(vecs[i].ec));
                check($sformatf("row%0d in_ready", i), DW'(in_ready), DW'(vecs[i].er));
            end
            next_cycle();
        end

        // flush while both entries (skid build) are occupied, with a live input
        drive(0, 0, 1, {3{32'h2A}}, 8'h66, 0);
        next_cycle();
        drive(0, 0, 1, {3{32'h2B}}, 8'h77, 0);
        next_cycle();
        drive(0, 1, 1, {3{32'h2C}}, 8'h88, 0);
        next_cycle();
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 0, '0, '0, 1);
            @(negedge clk);
            check($sformatf("flush_full%0d out_valid", i), DW'(out_valid), DW'(1'b0));
            check($sformatf("flush_full%0d out_ctrl", i), DW'(out_ctrl), DW'(8'h00));
            next_cycle();
        end

        // random valid/stall stream against an in-order scoreboard
        sent = 0;
        rcvd = 0;
        cyc  = 0;
        while (rcvd < 1000 && cyc < 20000) begin
            d = {$urandom, $urandom, $urandom};
            c = CW'($urandom);
            drive(0, 0, (sent < 1000) && ($urandom_range(0, 3) != 0), d, c, $urandom_range(0, 2) != 0);
            @(negedge clk);
            if (!out_valid)
                check("rand bubble ctrl", DW'(out_ctrl), DW'(8'h00));
            check("rand out_valid", DW'(out_valid), DW'(exp_q.size() != 0));
            if (SKID)
                check("rand in_ready", DW'(in_ready), DW'(exp_q.size() < 2));
            else
                check("rand in_ready", DW'(in_ready), DW'(exp_q.size() == 0 || out_ready));
            emt = out_valid && out_ready;
            acc = in_valid && in_ready;
            if (emt) begin
                if (exp_q.size() == 0) begin
                    check("rand unexpected emit", DW'(1'b1), DW'(1'b0));
                end else begin
                    check("rand data", out_data, exp_q.pop_front());
                    check("rand ctrl", DW'(out_ctrl), DW'(expc_q.pop_front()));
                end
                rcvd++;
            end
            if (acc) begin
                exp_q.push_back(in_data);
                expc_q.push_back(in_ctrl);
                sent++;
            end
            cyc++;
            next_cycle();
        end
        check("rand received count", DW'(rcvd), DW'(1000));
        check("rand leftover", DW'(exp_q.size()), DW'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
